// File: rtl/frame_drop_fifo_pkg.sv
// Shared stream definitions: default AXI-Stream widths, the write-side
// frame state and the pointer-width helper.
package frame_drop_fifo_pkg;

  localparam int unsigned STREAM_DATA_WIDTH = 32;
  localparam int unsigned STREAM_KEEP_WIDTH = 4;

  // Write side is either storing the current frame or discarding the rest of it.
  typedef enum logic {
    WR_PASS = 1'b0,
    WR_DROP = 1'b1
  } wr_state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/frame_drop_fifo_if.sv
// AXI-Stream bundle used on both sides of the frame FIFO.
interface frame_drop_fifo_if
  import frame_drop_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = STREAM_DATA_WIDTH,
  parameter int unsigned KEEP_WIDTH = STREAM_KEEP_WIDTH
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (
    output tdata, tkeep, tvalid, tlast, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast, tuser,
    output tready
  );

endinterface

// File: rtl/frame_drop_fifo_sdp_ram.sv
// Simple dual-port RAM with one write port and one registered read port.
// Contents are not reset; readers track validity themselves.
module sdp_ram
  import frame_drop_fifo_pkg::*;
#(
  parameter  int unsigned DEPTH  = 64,
  parameter  int unsigned WIDTH  = 37,
  localparam int unsigned ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/frame_drop_fifo.sv
// Store-and-forward AXI-Stream FIFO: only complete good frames are released;
// bad frames are rewound and frames that do not fit are dropped.
module frame_drop_fifo
  import frame_drop_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = STREAM_DATA_WIDTH,
  parameter int unsigned KEEP_ENABLE = 1,
  parameter int unsigned KEEP_WIDTH  = STREAM_KEEP_WIDTH,
  parameter int unsigned DEPTH       = 64
) (
  input  logic              clk,
  input  logic              rst,
  frame_drop_fifo_if.slave  s_axis,
  frame_drop_fifo_if.master m_axis,
  output logic              status_good_frame,
  output logic              status_bad_frame,
  output logic              status_overflow
);

  localparam int unsigned ADDR_W = clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam int unsigned RAM_W  = DATA_WIDTH + KEEP_WIDTH + 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

  wr_state_t        state, state_next;
  logic             drop_flag;
  logic [PTR_W-1:0] wr_ptr, wr_ptr_next;
  logic [PTR_W-1:0] wr_ptr_commit, wr_ptr_commit_next;
  logic [PTR_W-1:0] rd_ptr;
  logic             accept, full, mem_we;
  logic             good_next, bad_next, overflow_next;

  logic             avail, rd_en, stage_valid, stage_move;
  logic [RAM_W-1:0] ram_wdata, ram_rdata;
  logic [KEEP_WIDTH-1:0] keep_q;

  assign s_axis.tready = ~rst;
  assign accept        = s_axis.tvalid & s_axis.tready;
  assign drop_flag     = (state == WR_DROP);
  assign full          = ((wr_ptr - rd_ptr) == DEPTH_P);
  assign ram_wdata     = {s_axis.tlast, s_axis.tkeep, s_axis.tdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WR_PASS;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next         = state;
    wr_ptr_next        = wr_ptr;
    wr_ptr_commit_next = wr_ptr_commit;
    mem_we             = 1'b0;
    good_next          = 1'b0;
    bad_next           = 1'b0;
    overflow_next      = 1'b0;
    if (accept) begin
      if (drop_flag) begin
        if (s_axis.tlast) begin
          state_next    = WR_PASS;
          overflow_next = 1'b1;
        end
      end else if (full) begin
        // A tlast beat that hits full ends its own frame, so no drop state is needed.
        wr_ptr_next = wr_ptr_commit;
        if (s_axis.tlast) begin
          overflow_next = 1'b1;
        end else begin
          state_next = WR_DROP;
        end
      end else begin
        mem_we      = 1'b1;
        wr_ptr_next = wr_ptr + 1'b1;
        if (s_axis.tlast) begin
          if (s_axis.tuser) begin
            wr_ptr_next = wr_ptr_commit;
            bad_next    = 1'b1;
          end else begin
            wr_ptr_commit_next = wr_ptr + 1'b1;
            good_next          = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr            <= '0;
      wr_ptr_commit     <= '0;
      status_good_frame <= 1'b0;
      status_bad_frame  <= 1'b0;
      status_overflow   <= 1'b0;
    end else begin
      wr_ptr            <= wr_ptr_next;
      wr_ptr_commit     <= wr_ptr_commit_next;
      status_good_frame <= good_next;
      status_bad_frame  <= bad_next;
      status_overflow   <= overflow_next;
    end
  end

  sdp_ram #(
    .DEPTH (DEPTH),
    .WIDTH (RAM_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (ram_wdata),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (ram_rdata)
  );

  // RAM read register is a hidden stage ahead of the output register; it is
  // refilled in the same cycle it drains, which keeps output at one beat/cycle.
  assign avail      = (rd_ptr != wr_ptr_commit);
  assign stage_move = stage_valid & (~m_axis.tvalid | m_axis.tready);
  assign rd_en      = avail & (~stage_valid | stage_move);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr        <= '0;
      stage_valid   <= 1'b0;
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tlast  <= 1'b0;
      keep_q        <= '0;
    end else begin
      if (rd_en) begin
        rd_ptr      <= rd_ptr + 1'b1;
        stage_valid <= 1'b1;
      end else if (stage_move) begin
        stage_valid <= 1'b0;
      end
      if (stage_move) begin
        m_axis.tvalid <= 1'b1;
        m_axis.tdata  <= ram_rdata[DATA_WIDTH-1:0];
        keep_q        <= ram_rdata[DATA_WIDTH +: KEEP_WIDTH];
        m_axis.tlast  <= ram_rdata[RAM_W-1];
      end else if (m_axis.tready) begin
        m_axis.tvalid <= 1'b0;
      end
    end
  end

  assign m_axis.tkeep = (KEEP_ENABLE != 0) ? keep_q : '1;
  assign m_axis.tuser = 1'b0;

endmodule

// File: tb/tb_frame_drop_fifo.sv
// Directed bench for frame_drop_fifo: good/bad/overflow frames, back-pressure,
// mid-frame reset and pointer wrap, with hand-computed expected beats.
module tb_frame_drop_fifo;

  logic clk = 1'b0;
  logic rst;
  logic good, bad, ovf;

  always #5 clk = ~clk;

  frame_drop_fifo_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4)) s_if ();
  frame_drop_fifo_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4)) m_if ();

  frame_drop_fifo #(
    .DATA_WIDTH  (32),
    .KEEP_ENABLE (1),
    .KEEP_WIDTH  (4),
    .DEPTH       (64)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .s_axis            (s_if.slave),
    .m_axis            (m_if.master),
    .status_good_frame (good),
    .status_bad_frame  (bad),
    .status_overflow   (ovf)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic [36:0] got_q[$];
  int          xfer_q[$];
  int good_cnt, bad_cnt, ovf_cnt, good_cyc, bad_cyc;
  logic        stalled = 1'b0;
  logic [36:0] held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Output monitor: sampled on the falling edge, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("hold_valid", m_if.tvalid, 1);
        check("hold_beat", {m_if.tlast, m_if.tkeep, m_if.tdata}, held);
      end
      if (m_if.tvalid && m_if.tready) begin
        got_q.push_back({m_if.tlast, m_if.tkeep, m_if.tdata});
        xfer_q.push_back(cyc);
      end
      stalled = m_if.tvalid && !m_if.tready;
      held    = {m_if.tlast, m_if.tkeep, m_if.tdata};
      if (good) begin good_cnt++; good_cyc = cyc; end
      if (bad)  begin bad_cnt++;  bad_cyc  = cyc; end
      if (ovf)  ovf_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tlast  = l;
    s_if.tuser  = u;
    s_if.tvalid = 1'b1;
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear();
    got_q.delete();
    xfer_q.delete();
    good_cnt = 0; bad_cnt = 0; ovf_cnt = 0;
    good_cyc = 0; bad_cyc = 0;
  endtask

  task automatic expect_beat(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
    logic [36:0] g;
    g = '1;
    if (got_q.size() > 0) g = got_q.pop_front();
    check(tag, g, {l, k, d});
  endtask

  task automatic expect_status(input string tag, input int g, input int b, input int o);
    check({tag, "_good"}, good_cnt, g);
    check({tag, "_bad"}, bad_cnt, b);
    check({tag, "_ovf"}, ovf_cnt, o);
  endtask

  initial begin
    int a, lat;
    rst = 1'b1;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0;
    s_if.tlast = 1'b0;  s_if.tuser = 1'b0;
    m_if.tready = 1'b1;
    clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_tready", s_if.tready, 0);
    check("rst_m_tvalid", m_if.tvalid, 0);
    check("rst_m_beat", {m_if.tlast, m_if.tkeep, m_if.tdata}, 0);
    check("rst_pulses", {good, bad, ovf}, 0);
    check("rst_wr_ptr", dut.wr_ptr, 0);
    check("rst_rd_ptr", dut.rd_ptr, 0);
    check("rst_commit", dut.wr_ptr_commit, 0);
    check("rst_drop", dut.drop_flag, 0);
    rst = 1'b0;
    idle(1);
    check("s_tready_run", s_if.tready, 1);

    // Good 4-beat frame and commit-to-output latency
    clear();
    for (int i = 0; i < 4; i++) send_beat(32'(i + 1), 4'hF, i == 3, 1'b0);
    a = cyc;
    lat = -1;
    for (int w = 0; w < 10 && lat < 0; w++) begin
      @(negedge clk);
      if (m_if.tvalid) lat = cyc - a;
    end
    check("t1_latency", lat, 2);
    idle(10);
    for (int i = 0; i < 4; i++) expect_beat($sformatf("t1_beat%0d", i), 32'(i + 1), 4'hF, i == 3);
    check("t1_extra", got_q.size(), 0);
    expect_status("t1", 1, 0, 0);

    // Bad frame followed by good frame
    clear();
    send_beat(32'h90, 4'hF, 1'b0, 1'b0);
    send_beat(32'h91, 4'hF, 1'b0, 1'b0);
    send_beat(32'h92, 4'hF, 1'b1, 1'b1);
    send_beat(32'hA0, 4'hF, 1'b0, 1'b0);
    send_beat(32'hA1, 4'h3, 1'b1, 1'b0);
    idle(10);
    expect_beat("t2_beat0", 32'hA0, 4'hF, 1'b0);
    expect_beat("t2_beat1", 32'hA1, 4'h3, 1'b1);
    check("t2_extra", got_q.size(), 0);
    expect_status("t2", 1, 1, 0);
    check("t2_order", bad_cyc < good_cyc, 1);

    // Back-pressure with tready toggling 1010...
    clear();
    for (int i = 0; i < 8; i++) send_beat(32'h10 + 32'(i), 4'hF, i == 7, 1'b0);
    for (int c = 0; c < 24; c++) begin
      m_if.tready = (c % 2 == 0);
      idle(1);
    end
    m_if.tready = 1'b1;
    idle(5);
    for (int i = 0; i < 8; i++) expect_beat($sformatf("t3_beat%0d", i), 32'h10 + 32'(i), 4'hF, i == 7);
    check("t3_extra", got_q.size(), 0);
    expect_status("t3", 1, 0, 0);

    // Frame of exactly DEPTH beats fits while output is stalled
    clear();
    m_if.tready = 1'b0;
    for (int i = 0; i < 64; i++) send_beat(32'h200 + 32'(i), 4'hF, i == 63, 1'b0);
    idle(5);
    check("t4_stalled_out", got_q.size(), 0);
    expect_status("t4", 1, 0, 0);
    m_if.tready = 1'b1;
    idle(80);
    for (int i = 0; i < 64; i++) expect_beat($sformatf("t4_beat%0d", i), 32'h200 + 32'(i), 4'hF, i == 63);
    check("t4_extra", got_q.size(), 0);

    // Overflow: 70-beat frame dropped, following good frame intact
    clear();
    m_if.tready = 1'b0;
    for (int i = 0; i < 70; i++) send_beat(32'h300 + 32'(i), 4'hF, i == 69, 1'b0);
    send_beat(32'hB0, 4'hF, 1'b0, 1'b0);
    send_beat(32'hB1, 4'hF, 1'b1, 1'b0);
    idle(5);
    check("t5_stalled_out", got_q.size(), 0);
    expect_status("t5", 1, 0, 1);
    check("t5_drop_clear", dut.drop_flag, 0);
    m_if.tready = 1'b1;
    idle(10);
    expect_beat("t5_beat0", 32'hB0, 4'hF, 1'b0);
    expect_beat("t5_beat1", 32'hB1, 4'hF, 1'b1);
    check("t5_extra", got_q.size(), 0);

    // Reset after beat 3 of a 6-beat frame
    clear();
    for (int i = 0; i < 3; i++) send_beat(32'h40 + 32'(i), 4'hF, 1'b0, 1'b0);
    rst = 1'b1;
    s_if.tdata = 32'h43; s_if.tkeep = 4'hF; s_if.tlast = 1'b0; s_if.tvalid = 1'b1;
    idle(1);
    check("t6_rst_tready", s_if.tready, 0);
    check("t6_wr_ptr", dut.wr_ptr, 0);
    check("t6_rd_ptr", dut.rd_ptr, 0);
    check("t6_commit", dut.wr_ptr_commit, 0);
    check("t6_m_tvalid", m_if.tvalid, 0);
    s_if.tdata = 32'h44;
    idle(1);
    rst = 1'b0;
    s_if.tvalid = 1'b0;
    idle(5);
    check("t6_no_output", got_q.size(), 0);
    expect_status("t6_idle", 0, 0, 0);
    check("t6_tready", s_if.tready, 1);
    for (int i = 0; i < 3; i++) send_beat(32'hC0 + 32'(i), 4'hF, i == 2, 1'b0);
    idle(8);
    for (int i = 0; i < 3; i++) expect_beat($sformatf("t6_beat%0d", i), 32'hC0 + 32'(i), 4'hF, i == 2);
    check("t6_extra", got_q.size(), 0);
    expect_status("t6", 1, 0, 0);

    // 200 back-to-back 5-beat frames: order, no bubbles, pointer wrap
    clear();
    for (int f = 0; f < 200; f++)
      for (int b = 0; b < 5; b++) send_beat(32'(f * 5 + b), 4'hF, b == 4, 1'b0);
    idle(20);
    check("t7_span", (xfer_q.size() == 1000) ? (xfer_q[999] - xfer_q[0]) : -1, 999);
    for (int i = 0; i < 1000; i++) expect_beat($sformatf("t7_beat%0d", i), 32'(i), 4'hF, (i % 5) == 4);
    check("t7_extra", got_q.size(), 0);
    expect_status("t7", 200, 0, 0);
    check("t7_wr_ptr", dut.wr_ptr, 107);
    check("t7_rd_ptr", dut.rd_ptr, 107);
    check("t7_commit", dut.wr_ptr_commit, 107);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_drop_fifo.md
FRAME_DROP_FIFO -- requirements
Module: frame_drop_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32, tdata width in bits.
REQ-002 Parameter KEEP_ENABLE, default 1, propagate tkeep; when 0, m_axis_tkeep SHALL be all ones.
REQ-003 Parameter KEEP_WIDTH, default 4, tkeep width.
REQ-004 Parameter DEPTH, default 64, storage depth in beats, power of two, >= 4.
REQ-005 clk  in  1  single clock; one clock, reset is synchronous and active-high.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 s_axis_tdata/tkeep/tvalid/tlast/tuser  in  DATA_WIDTH/KEEP_WIDTH/1/1/1  input stream; tuser=1 on the tlast beat marks a bad frame.
REQ-008 s_axis_tready  out  1  input ready.
REQ-009 m_axis_tdata/tkeep/tvalid/tlast  out  DATA_WIDTH/KEEP_WIDTH/1/1  output stream, good frames only.
REQ-010 m_axis_tready  in  1  output ready.
REQ-011 status_good_frame, status_bad_frame, status_overflow  out  1 each  single-cycle event pulses.

Function
REQ-012 s_axis_tready SHALL be 1 whenever rst is low, so input is never back-pressured; overflow is handled by dropping.
REQ-013 Each accepted beat SHALL be written at wr_ptr, and wr_ptr SHALL increment; all pointers SHALL be log2(DEPTH)+1 bits and wrap naturally.
REQ-014 On an accepted tlast with tuser=0 and no drop pending, wr_ptr_commit SHALL take the post-increment wr_ptr, and status_good_frame SHALL pulse on the next cycle.
REQ-015 On an accepted tlast with tuser=1, wr_ptr SHALL rewind to wr_ptr_commit, and status_bad_frame SHALL pulse on the next cycle.
REQ-016 Full SHALL be defined as (wr_ptr - rd_ptr) == DEPTH.
REQ-017 A beat accepted while full SHALL set drop_flag and rewind wr_ptr to wr_ptr_commit; no data SHALL be written.
REQ-018 While drop_flag is set, beats SHALL be discarded; on tlast, drop_flag SHALL clear and status_overflow SHALL pulse on the next cycle, whatever the tuser value.
REQ-019 A frame longer than DEPTH beats SHALL always be dropped under REQ-017/018.
REQ-020 The read side SHALL only expose committed data: "data available" is rd_ptr != wr_ptr_commit.
REQ-021 The output SHALL be a single registered stage: the register loads when it is empty or when (m_axis_tvalid & m_axis_tready) and data is available.
REQ-022 With the output idle, the first beat of a committed frame SHALL appear on m_axis exactly 2 cycles after the clock edge that accepted its tlast.
REQ-023 With m_axis_tready held high, output throughput SHALL be one beat per cycle, with no bubbles between committed frames.
REQ-024 m_axis outputs SHALL hold stable while tvalid=1 and tready=0.
REQ-025 When commit and read happen in the same cycle, both SHALL take effect; when rewind and read happen in the same cycle, both SHALL take effect. No event SHALL be lost.
REQ-026 When a beat writes in the same cycle a full-freeing read occurs, full SHALL be evaluated on pre-edge pointers; that beat SHALL be dropped.

Reset
REQ-027 During rst, wr_ptr, wr_ptr_commit, rd_ptr, drop_flag, m_axis_tvalid, and all status pulses SHALL be 0, and s_axis_tready SHALL be 0.
REQ-028 m_axis_tdata/tkeep/tlast SHALL reset to 0.
REQ-029 Reset asserted mid-frame SHALL discard all stored and partial frames; the first beat after rst deasserts SHALL be treated as a frame start.
REQ-030 Memory contents SHALL NOT require reset.

Structure
REQ-031 The shared stream package SHALL hold the default widths (DATA_WIDTH=32, KEEP_WIDTH=4) and the pointer-width function clog2; status pulse definitions are local.
REQ-032 Storage SHALL be one sub-module, sdp_ram (simple dual-port, registered read, DEPTH x (DATA_WIDTH+KEEP_WIDTH+1)).

Verification
REQ-033 Good frame: 4 beats 0x01..0x04, tkeep=0xF, tuser=0 -> same 4 beats out, tlast on beat 4, first out 2 cycles after tlast, one status_good_frame pulse.
REQ-034 Bad frame then good frame: 3 beats with tuser=1 on last, then 2 beats 0xA0,0xA1 -> only 0xA0,0xA1 appear; one status_bad_frame pulse, then one status_good_frame pulse.
REQ-035 Overflow: DEPTH=64, m_axis_tready=0, 70-beat frame -> nothing output, status_overflow pulses once; a following 2-beat good frame is output intact.
REQ-036 Back-pressure: 8-beat frame with m_axis_tready toggling 1010... -> all 8 beats in order, data stable while stalled, no duplicates.
REQ-037 Reset mid-frame: rst high for 2 cycles after beat 3 of 6 -> no output, pointers 0, and the next good frame passes.
REQ-038 Wrap: 200 back-to-back 5-beat good frames with m_axis_tready=1 -> 1000 beats in order, no drops, pointers wrap cleanly.
